// File: rtl/pr_stream_ctrl.sv
// Initiator for the PR IP data port: pulses pr_start, streams length words, reports done/err.
// Latency: data/handshake is a zero-latency pass-through while streaming; control outputs registered.
// Backpressure: src_ready follows pr_data_ready while streaming and is held low in every other state.
module pr_stream_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int LEN_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  pr_start,
    output logic [DATA_WIDTH-1:0] pr_data,
    output logic                  pr_data_valid,
    input  logic                  pr_data_ready,
    input  logic [2:0]            pr_status,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            err_code
);
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_PR_ERR  = 3'b001;
    localparam logic [2:0] ST_CRC_ERR = 3'b010;
    localparam logic [2:0] ST_INCOMP  = 3'b011;
    localparam logic [2:0] ST_BUSY    = 3'b100;
    localparam logic [2:0] ST_OK      = 3'b101;
    localparam logic [2:0] CODE_TMO   = 3'b110;
    localparam logic [2:0] CODE_ZERO  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_STREAM,
        S_FIN,
        S_OK,
        S_FAIL
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] data_q;

    logic       in_stream;
    logic       xfer;
    logic       last_xfer;
    logic       st_err;
    logic       tmo_hit;
    logic       progress;
    logic       fail_vld;
    logic [2:0] fail_code;

    assign in_stream     = (state == S_STREAM);
    assign pr_data_valid = in_stream & src_valid;
    assign src_ready     = in_stream & pr_data_ready;
    assign pr_data       = in_stream ? src_data : data_q;
    assign xfer          = in_stream & src_valid & pr_data_ready;
    assign last_xfer     = ((word_cnt + LEN_WIDTH'(1)) == len_q);
    assign st_err        = (pr_status == ST_PR_ERR) || (pr_status == ST_CRC_ERR) ||
                           (pr_status == ST_INCOMP);
    assign tmo_hit       = (tmo_cnt == TMO_LAST);

    // A status error outranks everything, including a final transfer in the same cycle.
    always_comb begin
        progress  = 1'b0;
        fail_vld  = 1'b0;
        fail_code = pr_status;
        case (state)
            S_ACK:    progress = (pr_status == ST_BUSY);
            S_STREAM: progress = xfer;
            S_FIN:    progress = (pr_status == ST_OK);
            default:  progress = 1'b0;
        endcase
        if (state == S_ACK || state == S_STREAM || state == S_FIN) begin
            if (st_err) begin
                fail_vld = 1'b1;
            end else if (tmo_hit && !progress) begin
                fail_vld  = 1'b1;
                fail_code = CODE_TMO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            tmo_cnt  <= '0;
            data_q   <= '0;
            pr_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            pr_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (in_stream) begin
                data_q <= src_data;
            end
            if (fail_vld) begin
                state    <= S_FAIL;
                err      <= 1'b1;
                err_code <= fail_code;
                busy     <= 1'b0;
                tmo_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        tmo_cnt <= '0;
                        if (start) begin
                            if (length != '0) begin
                                len_q    <= length;
                                word_cnt <= '0;
                                err_code <= '0;
                                busy     <= 1'b1;
                                pr_start <= 1'b1;
                                state    <= S_REQ;
                            end else begin
                                err      <= 1'b1;
                                err_code <= CODE_ZERO;
                            end
                        end
                    end
                    S_REQ: begin
                        tmo_cnt <= '0;
                        state   <= S_ACK;
                    end
                    S_ACK: begin
                        if (pr_status == ST_BUSY) begin
                            tmo_cnt <= '0;
                            state   <= S_STREAM;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    S_STREAM: begin
                        // Each accepted word restarts the inactivity window.
                        if (xfer) begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                            tmo_cnt  <= '0;
                            if (last_xfer) begin
                                state <= S_FIN;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    S_FIN: begin
                        if (pr_status == ST_OK) begin
                            tmo_cnt <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_OK;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    S_OK, S_FAIL: begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pr_stream_ctrl.sv
// Bench for pr_stream_ctrl: phase-level reference model checked every cycle, plus
// directed scenarios with hand-computed word sequences, pulse counts and latencies.
module tb_pr_stream_ctrl;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [23:0] length;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        pr_start;
    logic [15:0] pr_data;
    logic        pr_data_valid;
    logic        pr_data_ready;
    logic [2:0]  pr_status;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    pr_stream_ctrl #(
        .DATA_WIDTH    (16),
        .LEN_WIDTH     (24),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .length       (length),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .pr_start     (pr_start),
        .pr_data      (pr_data),
        .pr_data_valid(pr_data_valid),
        .pr_data_ready(pr_data_ready),
        .pr_status    (pr_status),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_STREAM = 3, P_FIN = 4, P_OK = 5, P_FAIL = 6;

    int          total = 0;
    int          passed = 0;
    int          m_phase = P_IDLE;
    int          m_left = 0;
    int          m_wait = 0;
    logic [2:0]  m_code = 3'b000;
    bit          m_zl = 1'b0;

    int          src_mode = 0;
    bit          rdy_tog = 1'b0;
    int          src_idx = 0;
    logic [15:0] src_base = 16'h0000;
    int          ph = 0;
    logic [12:0] vpat = 13'b1011001101011;
    logic [15:0] sink[$];
    int          n_pstart = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_fail(input logic [2:0] code);
        m_phase = P_FAIL;
        m_code  = code;
    endtask

    // Advances the reference by one clock, using the inputs as they were before the edge.
    task automatic model_step();
        bit es;
        m_zl = 1'b0;
        if (!n_rst) begin
            m_phase = P_IDLE;
            m_code  = 3'b000;
            m_wait  = 0;
            m_left  = 0;
            return;
        end
        es = (pr_status == 3'b001) || (pr_status == 3'b010) || (pr_status == 3'b011);
        case (m_phase)
            P_IDLE: if (start) begin
                if (length != 24'd0) begin
                    m_left  = int'(length);
                    m_code  = 3'b000;
                    m_phase = P_REQ;
                end else begin
                    m_zl   = 1'b1;
                    m_code = 3'b111;
                end
            end
            P_REQ: begin
                m_phase = P_ACK;
                m_wait  = 0;
            end
            P_ACK: begin
                if (es) model_fail(pr_status);
                else if (pr_status == 3'b100) begin m_phase = P_STREAM; m_wait = 0; end
                else if (m_wait == TMO - 1) model_fail(3'b110);
                else m_wait++;
            end
            P_STREAM: begin
                if (es) model_fail(pr_status);
                else if (src_valid && pr_data_ready) begin
                    m_left--;
                    m_wait = 0;
                    if (m_left == 0) m_phase = P_FIN;
                end
                else if (m_wait == TMO - 1) model_fail(3'b110);
                else m_wait++;
            end
            P_FIN: begin
                if (es) model_fail(pr_status);
                else if (pr_status == 3'b101) begin m_phase = P_OK; m_wait = 0; end
                else if (m_wait == TMO - 1) model_fail(3'b110);
                else m_wait++;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare();
        bit strm;
        strm = (m_phase == P_STREAM);
        chk("busy", {31'd0, busy}, {31'd0, m_phase inside {P_REQ, P_ACK, P_STREAM, P_FIN}});
        chk("pr_start", {31'd0, pr_start}, {31'd0, m_phase == P_REQ});
        chk("done", {31'd0, done}, {31'd0, m_phase == P_OK});
        chk("err", {31'd0, err}, {31'd0, (m_phase == P_FAIL) || m_zl});
        chk("err_code", {29'd0, err_code}, {29'd0, m_code});
        chk("src_ready", {31'd0, src_ready}, {31'd0, strm && pr_data_ready});
        chk("pr_data_valid", {31'd0, pr_data_valid}, {31'd0, strm && src_valid});
        if (strm && src_valid) chk("pr_data", {16'd0, pr_data}, {16'd0, src_data});
        if (pr_start) n_pstart++;
        if (done) n_done++;
        if (err) n_err++;
    endtask

    // One clock: observe the edge, update model and source, drive new inputs, check at negedge.
    task automatic tick();
        bit src_xf;
        @(posedge clk);
        src_xf = src_valid && src_ready;
        if (pr_data_valid && pr_data_ready) sink.push_back(pr_data);
        model_step();
        if (src_xf) src_idx++;
        #1;
        ph++;
        if (rdy_tog) pr_data_ready = ~pr_data_ready;
        case (src_mode)
            0:       src_valid = 1'b0;
            1:       src_valid = 1'b1;
            default: src_valid = vpat[ph % 13];
        endcase
        src_data = src_base + 16'(src_idx);
        @(negedge clk);
        compare();
    endtask

    task automatic new_run(input logic [15:0] base, input int mode);
        sink.delete();
        src_idx  = 0;
        src_base = base;
        src_mode = mode;
        n_pstart = 0;
        n_done   = 0;
        n_err    = 0;
    endtask

    task automatic pulse_start(input logic [23:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_sink(input int cnt, input int bound);
        int i;
        for (i = 0; i < bound && sink.size() < cnt; i++) tick();
        if (i >= bound) chk("wait_sink_timeout", sink.size(), cnt);
    endtask

    task automatic wait_end(input int bound);
        int i;
        for (i = 0; i < bound && !done && !err; i++) tick();
        if (i >= bound) chk("wait_end_timeout", 0, 1);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; length = 24'd0; src_valid = 1'b0; src_data = 16'h0;
        pr_data_ready = 1'b0; pr_status = 3'b000;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err_code", {29'd0, err_code}, 0);
        chk("rst_pr_data", {16'd0, pr_data}, 0);
        n_rst = 1'b1;
        tick();

        // Normal run of four words.
        new_run(16'hA001, 1);
        pr_data_ready = 1'b1;
        pulse_start(24'd4);
        chk("norm_pr_start", {31'd0, pr_start}, 1);
        tick(); tick();
        pr_status = 3'b100;
        wait_sink(4, 50);
        pr_status = 3'b101;
        wait_end(20);
        chk("norm_done", {31'd0, done}, 1);
        tick();
        chk("norm_busy_after", {31'd0, busy}, 0);
        chk("norm_cnt", sink.size(), 4);
        for (int i = 0; i < 4; i++) chk("norm_word", {16'd0, sink[i]}, 32'hA001 + i);
        chk("norm_pstarts", n_pstart, 1);
        chk("norm_dones", n_done, 1);
        chk("norm_errs", n_err, 0);
        pr_status = 3'b000;

        // Backpressure, sparse source, and an ignored start while busy.
        new_run(16'hB000, 2);
        rdy_tog = 1'b1;
        pulse_start(24'd8);
        tick(); tick();
        pr_status = 3'b100;
        wait_sink(3, 100);
        pulse_start(24'd2);
        wait_sink(8, 200);
        pr_status = 3'b101;
        wait_end(20);
        chk("bp_done", {31'd0, done}, 1);
        tick();
        chk("bp_cnt", sink.size(), 8);
        for (int i = 0; i < 8; i++) chk("bp_word", {16'd0, sink[i]}, 32'hB000 + i);
        chk("bp_pstarts", n_pstart, 1);
        chk("bp_errs", n_err, 0);
        rdy_tog = 1'b0;
        pr_status = 3'b000;

        // CRC error after the third word.
        new_run(16'hC001, 1);
        pr_data_ready = 1'b1;
        pulse_start(24'd6);
        tick(); tick();
        pr_status = 3'b100;
        wait_sink(3, 50);
        pr_status = 3'b010;
        pr_data_ready = 1'b0;
        tick();
        chk("crc_err", {31'd0, err}, 1);
        chk("crc_code", {29'd0, err_code}, 32'h2);
        pr_data_ready = 1'b1;
        #1;
        chk("crc_src_ready", {31'd0, src_ready}, 0);
        tick();
        chk("crc_cnt", sink.size(), 3);
        chk("crc_no_done", n_done, 0);
        chk("crc_code_held", {29'd0, err_code}, 32'h2);
        pr_status = 3'b000;

        // Status never leaves idle: timeout 17 clocks after the pr_start cycle.
        new_run(16'h0000, 0);
        pulse_start(24'd4);
        n = 0;
        while (!err && n < 40) begin tick(); n++; end
        chk("tmo_latency", n, 17);
        chk("tmo_code", {29'd0, err_code}, 32'h6);
        tick();

        // Zero length request.
        pulse_start(24'd0);
        chk("zl_err", {31'd0, err}, 1);
        chk("zl_code", {29'd0, err_code}, 32'h7);
        chk("zl_busy", {31'd0, busy}, 0);
        tick();
        chk("zl_err_clear", {31'd0, err}, 0);

        // Reset in the middle of a stream, then a clean run.
        new_run(16'hD001, 1);
        pulse_start(24'd5);
        tick();
        pr_status = 3'b100;
        wait_sink(2, 50);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_valid", {31'd0, pr_data_valid}, 0);
        chk("mr_src_ready", {31'd0, src_ready}, 0);
        chk("mr_pr_data", {16'd0, pr_data}, 0);
        chk("mr_err", {31'd0, err | done | pr_start}, 0);
        pr_status = 3'b000;
        new_run(16'hE001, 1);
        tick();
        pulse_start(24'd3);
        tick(); tick();
        pr_status = 3'b100;
        wait_sink(3, 50);
        pr_status = 3'b101;
        wait_end(20);
        chk("mr_done", {31'd0, done}, 1);
        for (int i = 0; i < 3; i++) chk("mr_word", {16'd0, sink[i]}, 32'hE001 + i);
        chk("mr_errs", n_err, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
